// File: rtl/pulse_mode_sequencer.sv
// Button-driven pulse mode sequencer: debounced Next/Pre/Auto buttons select one of
// NUM_MODES quadrature patterns whose step length grows with the mode index.
module pulse_mode_sequencer #(
   parameter int NUM_MODES   = 4,
   parameter int DEB_CYCLES  = 1000000,
   parameter int AUTO_CYCLES = 50000000,
   parameter int BASE_DIV    = 1000
) (
   input  logic                         sysclk,
   input  logic                         Rst_n,
   input  logic                         Bt_Next,
   input  logic                         Bt_Pre,
   input  logic                         Bt_Auto,
   input  logic                         Enable,
   output logic [NUM_MODES-1:0]         Mode_Sel,
   output logic [$clog2(NUM_MODES)-1:0] Mode_Idx,
   output logic                         Auto_On,
   output logic                         Pulse_X,
   output logic                         Pulse_Y
);

   localparam int IDX_W  = $clog2(NUM_MODES);
   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int AUTO_W = $clog2(AUTO_CYCLES + 1);
   localparam int STEP_W = $clog2(BASE_DIV * NUM_MODES + 1);

   localparam logic [IDX_W-1:0]  MODE_LAST = IDX_W'(NUM_MODES - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

   function automatic logic [IDX_W-1:0] mode_inc(input logic [IDX_W-1:0] m);
      return (m == MODE_LAST) ? '0 : m + IDX_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] mode_dec(input logic [IDX_W-1:0] m);
      return (m == '0) ? MODE_LAST : m - IDX_W'(1);
   endfunction

   function automatic logic [STEP_W-1:0] step_last(input logic [IDX_W-1:0] k);
      return STEP_W'(BASE_DIV * (int'(k) + 1) - 1);
   endfunction

   // Bit order everywhere below: [0]=Next, [1]=Pre, [2]=Auto
   logic [2:0]       btn;
   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       deb_q, deb_d;
   logic [2:0]       stb_q, stb_d;
   logic [DEB_W-1:0] dcnt_q [3];
   logic [DEB_W-1:0] dcnt_d [3];

   assign btn = {Bt_Auto, Bt_Pre, Bt_Next};

   // Strobe is registered in the same cycle the debounced level rises
   always_comb begin
      for (int b = 0; b < 3; b++) begin
         deb_d[b]  = deb_q[b];
         dcnt_d[b] = '0;
         stb_d[b]  = 1'b0;
         if (sync2_q[b] != deb_q[b]) begin
            if (dcnt_q[b] == DEB_LAST) begin
               deb_d[b] = sync2_q[b];
               stb_d[b] = sync2_q[b];
            end else begin
               dcnt_d[b] = dcnt_q[b] + DEB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge sysclk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         stb_q   <= '0;
         for (int b = 0; b < 3; b++) dcnt_q[b] <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         stb_q   <= stb_d;
         for (int b = 0; b < 3; b++) dcnt_q[b] <= dcnt_d[b];
      end
   end

   logic              nxt, pre, aut;
   logic [IDX_W-1:0]  mode_q, mode_d;
   logic              auto_on_q, auto_on_d;
   logic [AUTO_W-1:0] acnt_q, acnt_d;

   assign nxt = stb_q[0] & Enable;
   assign pre = stb_q[1] & Enable;
   assign aut = stb_q[2] & Enable;

   // A manual strobe both suppresses and restarts the auto interval
   always_comb begin
      mode_d    = mode_q;
      auto_on_d = auto_on_q ^ aut;
      acnt_d    = acnt_q;
      if (!Enable || !auto_on_q || aut || nxt || pre) begin
         acnt_d = '0;
      end else if (acnt_q == AUTO_LAST) begin
         acnt_d = '0;
         mode_d = mode_inc(mode_q);
      end else begin
         acnt_d = acnt_q + AUTO_W'(1);
      end
      if (nxt && !pre) begin
         mode_d = mode_inc(mode_q);
      end else if (pre && !nxt) begin
         mode_d = mode_dec(mode_q);
      end
   end

   logic [STEP_W-1:0] step_q, step_d;
   logic [1:0]        phase_q, phase_d;
   logic              x_q, x_d, y_q, y_d;

   always_comb begin
      step_d  = step_q;
      phase_d = phase_q;
      if (!Enable || (mode_d != mode_q)) begin
         step_d  = '0;
         phase_d = '0;
      end else if (step_q == step_last(mode_q)) begin
         step_d  = '0;
         phase_d = phase_q + 2'd1;
      end else begin
         step_d = step_q + STEP_W'(1);
      end
      // Gray-coded phase: even modes put X first, odd modes put Y first
      if (mode_d[0]) begin
         x_d = phase_d[1];
         y_d = phase_d[1] ^ phase_d[0];
      end else begin
         x_d = phase_d[1] ^ phase_d[0];
         y_d = phase_d[1];
      end
   end

   always_ff @(posedge sysclk or negedge Rst_n) begin
      if (!Rst_n) begin
         mode_q    <= '0;
         auto_on_q <= 1'b0;
         acnt_q    <= '0;
         step_q    <= '0;
         phase_q   <= '0;
         x_q       <= 1'b0;
         y_q       <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         auto_on_q <= auto_on_d;
         acnt_q    <= acnt_d;
         step_q    <= step_d;
         phase_q   <= phase_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   assign Mode_Idx = mode_q;
   assign Mode_Sel = NUM_MODES'(1) << mode_q;
   assign Auto_On  = auto_on_q;
   assign Pulse_X  = x_q;
   assign Pulse_Y  = y_q;

endmodule

// File: tb/tb_pulse_mode_sequencer.sv
// Scoreboard bench for pulse_mode_sequencer with small parameters: stimulus queues
// expected mode/auto changes with their cycle stamps, a monitor checks each change.
module tb_pulse_mode_sequencer;

   logic       sysclk = 1'b0;
   logic       Rst_n  = 1'b0;
   logic       Enable = 1'b1;
   logic [2:0] btn    = 3'b000;
   logic [3:0] Mode_Sel;
   logic [1:0] Mode_Idx;
   logic       Auto_On, Pulse_X, Pulse_Y;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int mode;
      int aut;
      int cyc;
   } exp_t;
   exp_t sb[$];

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   pulse_mode_sequencer #(
      .NUM_MODES(4), .DEB_CYCLES(4), .AUTO_CYCLES(64), .BASE_DIV(2)
   ) dut (
      .sysclk  (sysclk),
      .Rst_n   (Rst_n),
      .Bt_Next (btn[0]),
      .Bt_Pre  (btn[1]),
      .Bt_Auto (btn[2]),
      .Enable  (Enable),
      .Mode_Sel(Mode_Sel),
      .Mode_Idx(Mode_Idx),
      .Auto_On (Auto_On),
      .Pulse_X (Pulse_X),
      .Pulse_Y (Pulse_Y)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mode_idx"}, Mode_Idx, 0);
      check({tag, "_mode_sel"}, Mode_Sel, 1);
      check({tag, "_auto_on"}, Auto_On, 0);
      check({tag, "_pulse_x"}, Pulse_X, 0);
      check({tag, "_pulse_y"}, Pulse_Y, 0);
   endtask

   // Monitor: any change of Mode_Idx/Auto_On outside reset must match the queue head
   initial begin
      int   pm, pa;
      exp_t e;
      pm = 0;
      pa = 0;
      forever begin
         @(negedge sysclk);
         if (Rst_n && (int'(Mode_Idx) != pm || int'(Auto_On) != pa)) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_change mode=%0d auto=%0d cyc=%0d required no change",
                        Mode_Idx, Auto_On, cyc);
            end else begin
               e = sb.pop_front();
               check("sb_mode", Mode_Idx, e.mode);
               check("sb_auto", Auto_On, e.aut);
               check("sb_change_cycle", cyc, e.cyc);
               check("sb_mode_sel", Mode_Sel, 1 << e.mode);
            end
         end
         pm = Mode_Idx;
         pa = Auto_On;
      end
   end

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge sysclk);
   endtask

   // Press at a negedge; a change lands 7 cycles later (2 sync + 4 debounce + 1)
   task automatic press(input logic [2:0] mask, input bit chg, input int m, input int a,
                        output int t);
      t   = cyc;
      btn = mask;
      if (chg) sb.push_back('{mode: m, aut: a, cyc: t + 7});
      repeat (8) @(negedge sysclk);
      btn = 3'b000;
      repeat (10) @(negedge sysclk);
   endtask

   // Pattern from restart edge e0 with step S = 2*(m+1): phase = (k/S) mod 4
   task automatic check_pattern(input int e0, input int m, input int n);
      int k, s, ph, ex, ey;
      s = 2 * (m + 1);
      repeat (n) begin
         @(negedge sysclk);
         k  = cyc - e0;
         ph = (k / s) % 4;
         if (m % 2 == 0) begin
            ex = (ph == 1 || ph == 2) ? 1 : 0;
            ey = (ph >= 2) ? 1 : 0;
         end else begin
            ex = (ph >= 2) ? 1 : 0;
            ey = (ph == 1 || ph == 2) ? 1 : 0;
         end
         check($sformatf("pulse_x_m%0d_k%0d", m, k), Pulse_X, ex);
         check($sformatf("pulse_y_m%0d_k%0d", m, k), Pulse_Y, ey);
      end
   endtask

   initial begin
      int t, e0, big_t, nz;

      repeat (3) @(negedge sysclk);
      check_reset_outputs("por");
      #2 Rst_n = 1'b1;
      e0 = cyc;
      check_pattern(e0, 0, 20);

      press(3'b001, 1'b1, 1, 0, t);
      press(3'b001, 1'b1, 2, 0, t);
      press(3'b001, 1'b1, 3, 0, t);
      check_pattern(t + 7, 3, 40);
      press(3'b010, 1'b1, 2, 0, t);
      press(3'b010, 1'b1, 1, 0, t);
      press(3'b010, 1'b1, 0, 0, t);
      press(3'b010, 1'b1, 3, 0, t);

      btn = 3'b001;
      repeat (3) @(negedge sysclk);
      btn = 3'b000;
      repeat (12) @(negedge sysclk);

      press(3'b010, 1'b1, 2, 0, t);
      t     = cyc;
      big_t = t + 7;
      btn   = 3'b100;
      sb.push_back('{mode: 2, aut: 1, cyc: big_t});
      sb.push_back('{mode: 3, aut: 1, cyc: big_t + 64});
      sb.push_back('{mode: 0, aut: 1, cyc: big_t + 128});
      sb.push_back('{mode: 1, aut: 1, cyc: big_t + 192});
      repeat (8) @(negedge sysclk);
      btn = 3'b000;

      wait_until(big_t + 215);
      press(3'b001, 1'b1, 2, 1, t);
      sb.push_back('{mode: 3, aut: 1, cyc: big_t + 286});

      wait_until(big_t + 291);
      btn = 3'b010;
      sb.push_back('{mode: 2, aut: 1, cyc: big_t + 298});
      wait_until(big_t + 306);
      btn = 3'b000;
      check("mid_pattern_x", Pulse_X, 1);
      check("mid_pattern_y", Pulse_Y, 0);
      btn = 3'b001;
      #3 Rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      check("sb_drained_before_rst", sb.size(), 0);
      @(negedge sysclk);
      btn = 3'b000;
      repeat (3) @(negedge sysclk);
      #2 Rst_n = 1'b1;
      e0 = cyc;
      check_pattern(e0, 0, 24);

      press(3'b011, 1'b0, 0, 0, t);

      Enable = 1'b0;
      btn    = 3'b001;
      nz     = 0;
      for (int i = 0; i < 18; i++) begin
         @(negedge sysclk);
         if (Pulse_X || Pulse_Y) nz++;
         if (i == 8) btn = 3'b000;
      end
      check("pulses_while_disabled", nz, 0);

      btn = 3'b001;
      repeat (10) @(negedge sysclk);
      Enable = 1'b1;
      repeat (5) @(negedge sysclk);
      btn = 3'b000;
      repeat (12) @(negedge sysclk);

      check("final_mode_idx", Mode_Idx, 0);
      check("final_auto_on", Auto_On, 0);
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
